// File: rtl/button_event_detect.sv
// button_event_detect: synchronised, debounced push-buttons with press/release/long-press events and a press counter
module button_event_detect #(
  parameter int NUM_BTN = 4,
  parameter int DEBOUNCE_CYC = 120000,
  parameter int LONG_CYC = 12000000,
  parameter logic [NUM_BTN-1:0] ACTIVE_LOW = 4'b0001
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long,
  output logic [7:0] press_count
);
  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam int LW = LONG_CYC > 1 ? $clog2(LONG_CYC) : 1;
  typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;
  logic [7:0] pc;
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    logic s1, s2, p, hit, lvl, prs, rel, lng;
    logic [DW-1:0] dcnt;
    logic [LW-1:0] hcnt;
    state_t st;
    assign p = s2 ^ ACTIVE_LOW[i];
    assign hit = p != lvl && dcnt == DW'(DEBOUNCE_CYC - 1);
    assign btn_level[i] = lvl;
    assign btn_press[i] = prs;
    assign btn_release[i] = rel;
    assign btn_long[i] = lng;
    always_ff @(posedge clk) begin
      if (rst) begin
        s1 <= ACTIVE_LOW[i];
        s2 <= ACTIVE_LOW[i];
        dcnt <= '0;
        hcnt <= '0;
        st <= IDLE;
        lvl <= 1'b0;
        prs <= 1'b0;
        rel <= 1'b0;
        lng <= 1'b0;
      end else begin
        s1 <= btn_in[i];
        s2 <= s1;
        dcnt <= (p == lvl || hit) ? '0 : dcnt + 1'b1;
        lvl <= hit ? p : lvl;
        prs <= hit && p;
        rel <= hit && !p && st != IDLE;
        lng <= !hit && st == HELD && hcnt == LW'(LONG_CYC - 1);
        if (hit && !p) begin
          st <= IDLE;
        end else if (hit && p) begin
          st <= HELD;
          hcnt <= '0;
        end else if (st == HELD) begin
          if (hcnt == LW'(LONG_CYC - 1)) st <= LONG;
          else hcnt <= hcnt + 1'b1;
        end
      end
    end
  end
  always_comb begin
    pc = '0;
    for (int k = 0; k < NUM_BTN; k++) pc = pc + 8'(btn_press[k]);
  end
  always_ff @(posedge clk) begin
    if (rst) press_count <= '0;
    else press_count <= press_count + pc;
  end
endmodule

// File: tb/tb_button_event_detect.sv
// tb_button_event_detect: directed stimulus checked every cycle against a sliding-window behavioural model
module tb_button_event_detect;
  localparam int N = 4;
  localparam int D = 4;
  localparam int L = 20;
  localparam logic [3:0] AL = 4'b0001;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] btn_in = AL;
  logic [3:0] btn_level, btn_press, btn_release, btn_long;
  logic [7:0] press_count;
  int total = 0, bad = 0, cyc = 0;
  int n_long0 = 0, n_rel0 = 0, n_rel1 = 0, press0_cyc = 0, long0_cyc = 0, r1 = 0;

  button_event_detect #(.NUM_BTN(N), .DEBOUNCE_CYC(D), .LONG_CYC(L), .ACTIVE_LOW(AL)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_long(btn_long), .press_count(press_count)
  );

  always #5 clk = ~clk;

  // Model: a level flips once the last D effective samples all disagree with it
  logic [3:0] m_level, m_press, m_rel, m_long, d1, d2;
  logic [7:0] m_count;
  logic [D-1:0] win [N];
  int age [N];
  bit started = 0;
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      started = 1;
      m_level = '0; m_press = '0; m_rel = '0; m_long = '0; m_count = '0; d1 = '0; d2 = '0;
      for (int i = 0; i < N; i++) begin
        win[i] = '0;
        age[i] = 0;
      end
    end else begin
      m_count = m_count + 8'($countones(m_press));
      m_press = '0; m_rel = '0; m_long = '0;
      for (int i = 0; i < N; i++) begin
        win[i] = {win[i][D-2:0], d2[i]};
        if (win[i] == {D{~m_level[i]}}) begin
          m_level[i] = ~m_level[i];
          if (m_level[i]) begin
            m_press[i] = 1'b1;
            age[i] = 0;
          end else m_rel[i] = 1'b1;
        end else if (m_level[i]) begin
          age[i]++;
          if (age[i] == L) m_long[i] = 1'b1;
        end
      end
      d2 = d1;
      d1 = btn_in ^ AL;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("level", 8'(btn_level), 8'(m_level));
      check("press", 8'(btn_press), 8'(m_press));
      check("release", 8'(btn_release), 8'(m_rel));
      check("long", 8'(btn_long), 8'(m_long));
      check("count", press_count, m_count);
      if (btn_press[0] === 1'b1) press0_cyc = cyc;
      if (btn_long[0] === 1'b1) begin
        n_long0++;
        long0_cyc = cyc;
      end
      if (btn_release[0] === 1'b1) n_rel0++;
      if (btn_release[1] === 1'b1) n_rel1++;
    end
  end

  task automatic press_group(input logic [3:0] m);
    btn_in = AL ^ m;
    repeat (8) @(negedge clk);
    btn_in = AL;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 check("rst_lvl_prs", {btn_level, btn_press}, 8'h00);
    check("rst_rel_lng", {btn_release, btn_long}, 8'h00);
    check("rst_count", press_count, 8'h00);
    @(negedge clk) rst = 1'b0;
    repeat (50) @(posedge clk);
    #1 check("idle_lvl_prs", {btn_level, btn_press}, 8'h00);
    check("idle_rel_lng", {btn_release, btn_long}, 8'h00);
    check("idle_count", press_count, 8'h00);
    // clean press of btn1
    @(negedge clk) btn_in[1] = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("t2_level_early", 8'(btn_level[1]), 8'h00);
    @(posedge clk);
    #1 check("t2_level", 8'(btn_level[1]), 8'h01);
    check("t2_press", 8'(btn_press[1]), 8'h01);
    @(posedge clk);
    #1 check("t2_press_end", 8'(btn_press[1]), 8'h00);
    check("t2_count", press_count, 8'h01);
    @(negedge clk) btn_in[1] = 1'b0;
    repeat (12) @(negedge clk);
    // bounce on btn2
    for (int j = 0; j < 10; j++) begin
      btn_in[2] = ~btn_in[2];
      repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("t3_level", 8'(btn_level[2]), 8'h00);
    check("t3_count", press_count, 8'h01);
    // long press on active-low btn0
    btn_in[0] = 1'b0;
    repeat (40) @(negedge clk);
    btn_in[0] = 1'b1;
    repeat (12) @(negedge clk);
    check("t4_long_once", 8'(n_long0), 8'h01);
    check("t4_long_delay", 8'(long0_cyc - press0_cyc), 8'd20);
    check("t4_release", 8'(n_rel0), 8'h01);
    btn_in[0] = 1'b0;
    repeat (10) @(negedge clk);
    btn_in[0] = 1'b1;
    repeat (12) @(negedge clk);
    check("t4_short_nolong", 8'(n_long0), 8'h01);
    check("t4_short_rel", 8'(n_rel0), 8'h02);
    check("t4_count", press_count, 8'h03);
    // simultaneous btn1..3
    btn_in = AL ^ 4'b1110;
    repeat (5) @(posedge clk);
    @(posedge clk);
    #1 check("t5_press3", 8'(btn_press), 8'h0e);
    @(posedge clk);
    #1 check("t5_count", press_count, 8'h06);
    @(negedge clk) btn_in = AL;
    repeat (12) @(negedge clk);
    // wrap
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 84; j++) press_group(4'b1110);
    press_group(4'b0110);
    check("t5_preload", press_count, 8'd254);
    press_group(4'b1110);
    check("t5_wrap", press_count, 8'd1);
    // reset while btn1 held
    btn_in = AL ^ 4'b0010;
    repeat (10) @(negedge clk);
    check("t6_held", 8'(btn_level[1]), 8'h01);
    r1 = n_rel1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_norel", 8'(n_rel1 - r1), 8'h00);
    check("t6_rst_level", 8'(btn_level), 8'h00);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("t6_press_early", 8'(btn_press[1]), 8'h00);
    @(posedge clk);
    #1 check("t6_press", 8'(btn_press[1]), 8'h01);
    @(negedge clk) btn_in = AL;
    repeat (12) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
